// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry layout,
// forwarding select encoding and the forwarding priority helper.
package cpu_pkg;

    localparam int REG_AW_DEFAULT = 4;
    // Scoreboard address fields are stored at this width; REG_AW must not exceed it.
    localparam int REG_AW_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic                  wre;
        logic [REG_AW_MAX-1:0] rd;
        logic                  is_load;
        logic [REG_AW_MAX-1:0] rs1;
        logic [REG_AW_MAX-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } sb_entry_t;

    // Nearest producer wins; a load still in MEM cannot supply data, so no forward.
    function automatic fwd_sel_t fwd_pick(input logic ex_valid, input logic mem_hit,
                                          input logic mem_is_load, input logic wb_hit);
        fwd_sel_t sel;
        if (!ex_valid) begin
            sel = FWD_RF;
        end else if (mem_hit) begin
            sel = mem_is_load ? FWD_RF : FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one register address against one scoreboard entry's destination.
module hazard_match #(
    parameter int AW = 4
) (
    input  logic [AW-1:0] addr,
    input  logic          used,
    input  logic          ent_valid,
    input  logic          ent_wre,
    input  logic [AW-1:0] ent_rd,
    output logic          hit
);

    assign hit = used & ent_valid & ent_wre & (ent_rd == addr);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall, flush and forwarding control for a five-stage pipeline with decode-stage branches.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEFAULT,
    parameter int TRACK_DEPTH = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wre,
    input  logic              id_is_load,
    input  logic              id_is_branch,
    input  logic              branch_taken,
    output logic              stall,
    output logic              bubble_de,
    output logic              flush_fd,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    sb_entry_t [TRACK_DEPTH-1:0] sb_q;
    sb_entry_t [TRACK_DEPTH-1:0] sb_d;
    sb_entry_t                   dec_entry_s;
    sb_entry_t                   e0_s;
    sb_entry_t                   e1_s;

    logic [REG_AW_MAX-1:0] dec_addr_s [2];
    logic [1:0]            dec_use_s;
    logic [REG_AW_MAX-1:0] ex_addr_s  [2];
    logic [1:0]            ex_use_s;
    logic [1:0]            dec_hit_ex_s;
    logic [1:0]            dec_hit_mem_s;
    logic [1:0]            ex_hit_mem_s;
    logic [1:0]            ex_hit_wb_s;
    logic                  load_use_s;
    logic                  branch_haz_s;
    logic                  stall_s;
    logic                  flush_s;
    logic                  unused_sb_s;

    assign e0_s = sb_q[0];
    assign e1_s = sb_q[1];

    assign dec_addr_s[0] = REG_AW_MAX'(id_rs1);
    assign dec_addr_s[1] = REG_AW_MAX'(id_rs2);
    assign dec_use_s     = {id_use_rs2, id_use_rs1};
    assign ex_addr_s[0]  = e0_s.rs1;
    assign ex_addr_s[1]  = e0_s.rs2;
    assign ex_use_s      = {e0_s.use_rs2, e0_s.use_rs1};

    for (genvar s = 0; s < 2; s++) begin : g_src
        hazard_match #(.AW(REG_AW_MAX)) u_dec_ex (
            .addr(dec_addr_s[s]), .used(dec_use_s[s]),
            .ent_valid(e0_s.valid), .ent_wre(e0_s.wre), .ent_rd(e0_s.rd),
            .hit(dec_hit_ex_s[s])
        );
        hazard_match #(.AW(REG_AW_MAX)) u_dec_mem (
            .addr(dec_addr_s[s]), .used(dec_use_s[s]),
            .ent_valid(e1_s.valid), .ent_wre(e1_s.wre), .ent_rd(e1_s.rd),
            .hit(dec_hit_mem_s[s])
        );
        hazard_match #(.AW(REG_AW_MAX)) u_ex_mem (
            .addr(ex_addr_s[s]), .used(ex_use_s[s]),
            .ent_valid(e1_s.valid), .ent_wre(e1_s.wre), .ent_rd(e1_s.rd),
            .hit(ex_hit_mem_s[s])
        );
        if (TRACK_DEPTH >= 3) begin : g_wb
            hazard_match #(.AW(REG_AW_MAX)) u_ex_wb (
                .addr(ex_addr_s[s]), .used(1'b1),
                .ent_valid(sb_q[2].valid), .ent_wre(sb_q[2].wre), .ent_rd(sb_q[2].rd),
                .hit(ex_hit_wb_s[s])
            );
        end else begin : g_no_wb
            assign ex_hit_wb_s[s] = 1'b0;
        end
    end

    // A branch resolving in decode also waits for a load that is still in MEM.
    assign load_use_s   = id_valid & e0_s.is_load & (|dec_hit_ex_s);
    assign branch_haz_s = id_valid & id_is_branch &
                          ((|dec_hit_ex_s) | (e1_s.is_load & (|dec_hit_mem_s)));
    assign stall_s      = load_use_s | branch_haz_s;
    assign flush_s      = id_valid & id_is_branch & branch_taken & ~stall_s;

    assign stall     = stall_s;
    assign bubble_de = stall_s;
    assign flush_fd  = flush_s;
    assign fwd_sel_a = fwd_pick(e0_s.valid, ex_hit_mem_s[0], e1_s.is_load, ex_hit_wb_s[0]);
    assign fwd_sel_b = fwd_pick(e0_s.valid, ex_hit_mem_s[1], e1_s.is_load, ex_hit_wb_s[1]);

    // Decode fields enter EX only when the instruction actually advances.
    always_comb begin
        dec_entry_s = '0;
        if (id_valid && !stall_s) begin
            dec_entry_s.valid   = 1'b1;
            dec_entry_s.wre     = id_wre;
            dec_entry_s.rd      = REG_AW_MAX'(id_rd);
            dec_entry_s.is_load = id_is_load;
            dec_entry_s.rs1     = REG_AW_MAX'(id_rs1);
            dec_entry_s.rs2     = REG_AW_MAX'(id_rs2);
            dec_entry_s.use_rs1 = id_use_rs1;
            dec_entry_s.use_rs2 = id_use_rs2;
        end else begin
            dec_entry_s = '0;
        end
    end

    // Next scoreboard: new EX entry in slot 0, every older slot shifts down.
    always_comb begin
        sb_d    = '0;
        sb_d[0] = dec_entry_s;
        for (int i = 1; i < TRACK_DEPTH; i++) begin
            sb_d[i] = sb_q[i-1];
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign unused_sb_s = ^sb_q;

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w_s;
    assign unused_cnt_w_s = '0;
`endif

endmodule
